// File: rtl/sha_pkg.sv
// -----------------------------------------------------------------------------
// sha_pkg
// Shared definitions for the SHA arbiter slice: datapath widths, the length of
// the engine reset pulse issued before every message, and the arbiter FSM
// state type.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package sha_pkg;

    localparam int SHA_WORD_W    = 32;
    localparam int SHA_HASH_W    = 512;

    // Number of cycles sha_rst is held high in CLEAR before a message is fed.
    localparam int SHA_CLR_LEN   = 2;
    localparam int SHA_CLR_CNT_W = (SHA_CLR_LEN > 1) ? $clog2(SHA_CLR_LEN) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } sha_state_e;

endpackage : sha_pkg

// File: rtl/sha_rr_arb2.sv
// -----------------------------------------------------------------------------
// sha_rr_arb2
// Two-requester round-robin grant selection (purely combinational).
//
// Ports:
//   req       in  2  request vector
//   last_gnt  in  1  index of the requester granted last (round-robin pointer)
//   gnt       out 1  index of the selected requester (valid when any = 1)
//   any       out 1  at least one request is pending
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module sha_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic       gnt,
    output logic       any
);

    assign any = |req;

    // NOTE: every output of an always_comb block is assigned on every path
    // (here by the if/else pair) so no latch is inferred.
    always_comb begin
        if (&req) begin
            // Tie: the requester that did not win last time goes first.
            gnt = ~last_gnt;
        end else begin
            // Zero or one request: pick requester 1 only if it is the one asking.
            gnt = req[1];
        end
    end

endmodule : sha_rr_arb2

// File: rtl/sha_arbiter.sv
// -----------------------------------------------------------------------------
// sha_arbiter
// Shares one SHA hashing engine between two requesters. A granted requester
// owns the engine for a whole message: engine reset (CLEAR), word streaming
// (FEED), result wait (WAIT) and response handshake (RESP).
//
// Configuration macro: SHA_ARB_TIMEOUT_EN
//   defined   - WAIT aborts after TIMEOUT_CYCLES cycles with resp_err=1 and a
//               zero digest.
//   undefined - WAIT waits for the engine indefinitely; resp_err is always 0.
//
// Ports:
//   clk_i              in   1    clock, all logic posedge-triggered
//   rst_i              in   1    asynchronous active-high reset
//   req_valid          in   2    per-requester word valid
//   req_data0/1        in   32   message words of requester 0 / 1
//   req_last           in   2    per-requester last-word flag
//   req_ready          out  2    per-requester word accept
//   resp_valid         out  2    one-hot digest available to the owner
//   resp_ack           in   2    per-requester response consume
//   resp_hash          out  512  captured digest
//   resp_err           out  1    timeout flag, qualified by resp_valid
//   sha_rst            out  1    engine reset
//   sha_data           out  32   engine word
//   sha_data_valid     out  1    engine word valid
//   sha_data_last      out  1    engine last-word flag
//   sha_data_in_ready  in   1    engine word accept
//   sha_hash           in   512  engine digest
//   sha_out_valid      in   1    engine digest valid
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module sha_arbiter
    import sha_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [1:0]            req_valid,
    input  logic [SHA_WORD_W-1:0] req_data0,
    input  logic [SHA_WORD_W-1:0] req_data1,
    input  logic [1:0]            req_last,
    output logic [1:0]            req_ready,
    output logic [1:0]            resp_valid,
    input  logic [1:0]            resp_ack,
    output logic [SHA_HASH_W-1:0] resp_hash,
    output logic                  resp_err,
    output logic                  sha_rst,
    output logic [SHA_WORD_W-1:0] sha_data,
    output logic                  sha_data_valid,
    output logic                  sha_data_last,
    input  logic                  sha_data_in_ready,
    input  logic [SHA_HASH_W-1:0] sha_hash,
    input  logic                  sha_out_valid
);

    sha_state_e               state;
    logic                     gnt_q;     // owner of the current message
    logic                     rr_ptr;    // requester granted last
    logic [SHA_CLR_CNT_W-1:0] clr_cnt;
    logic                     arb_gnt;
    logic                     arb_any;
    logic                     xfer;
    logic                     tmo_hit;
    logic [1:0]               gnt_onehot;

    sha_rr_arb2 u_rr_arb (
        .req      (req_valid),
        .last_gnt (rr_ptr),
        .gnt      (arb_gnt),
        .any      (arb_any)
    );

    assign gnt_onehot = {gnt_q, ~gnt_q};
    assign xfer       = (state == ST_FEED) && req_valid[gnt_q] && sha_data_in_ready;

    // The engine is held in reset both by the arbiter reset and during CLEAR.
    assign sha_rst    = rst_i || (state == ST_CLEAR);

    // Engine feed and requester back-pressure are direct forwards of the owner
    // while in FEED; everything is parked at zero otherwise.
    always_comb begin
        req_ready      = 2'b00;
        sha_data       = '0;
        sha_data_valid = 1'b0;
        sha_data_last  = 1'b0;
        if (state == ST_FEED) begin
            req_ready[gnt_q] = sha_data_in_ready;
            sha_data         = gnt_q ? req_data1 : req_data0;
            sha_data_valid   = req_valid[gnt_q];
            sha_data_last    = req_last[gnt_q];
        end
    end

`ifdef SHA_ARB_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TMO_W-1:0] tmo_cnt;

    // Zero outside WAIT, so the count starts from 0 on every WAIT entry.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_cnt <= '0;
        end else if (state != ST_WAIT) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign tmo_hit = (state == ST_WAIT) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    logic [31:0] unused_timeout_cycles;

    assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
    assign tmo_hit               = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            gnt_q      <= 1'b0;
            rr_ptr     <= 1'b1;
            clr_cnt    <= '0;
            resp_valid <= 2'b00;
            // NOTE: the wide digest register is reset deliberately: it is a
            // visible output whose value must be zero straight out of reset.
            resp_hash  <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        gnt_q   <= arb_gnt;
                        clr_cnt <= '0;
                        state   <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    if (clr_cnt == SHA_CLR_CNT_W'(SHA_CLR_LEN - 1)) begin
                        state <= ST_FEED;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                ST_FEED: begin
                    if (xfer && req_last[gnt_q]) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (sha_out_valid) begin
                        resp_hash  <= sha_hash;
                        resp_valid <= gnt_onehot;
                        resp_err   <= 1'b0;
                        state      <= ST_RESP;
                    end else if (tmo_hit) begin
                        resp_hash  <= '0;
                        resp_valid <= gnt_onehot;
                        resp_err   <= 1'b1;
                        state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    // Only the owner's acknowledge ends the transaction.
                    if (resp_ack[gnt_q]) begin
                        resp_valid <= 2'b00;
                        resp_err   <= 1'b0;
                        rr_ptr     <= gnt_q;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : sha_arbiter
